// File: rtl/mem_miss_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_miss_arbiter
//  Description : Arbitrates I$ and D$ line-miss requests onto one main-memory
//                port. Holds one pending request per cache, inserts a fixed
//                request latency, tracks the single outstanding transaction,
//                routes the response back by cache id, and forces a bus-error
//                response when memory stops answering.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_miss_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int LAT_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              icache_req_valid,
  input  logic [ADDR_W-1:0] icache_req_addr,
  input  logic              dcache_req_valid,
  input  logic [ADDR_W-1:0] dcache_req_addr,
  input  logic              dcache_req_store,
  input  logic [LINE_W-1:0] dcache_req_data,
  output logic              mm_req_valid,
  input  logic              mm_req_ready,
  output logic [ADDR_W-1:0] mm_req_addr,
  output logic              mm_req_store,
  output logic [LINE_W-1:0] mm_req_data,
  input  logic              mm_rsp_valid,
  input  logic [LINE_W-1:0] mm_rsp_data,
  input  logic              mm_rsp_error,
  output logic              rsp_valid,
  output logic              rsp_cache_id,
  output logic [LINE_W-1:0] rsp_data,
  output logic              rsp_bus_error,
  output logic              protocol_err
);

  // One counter serves both the DELAY phase and the WAIT_RSP watchdog.
  localparam int                 c_CNT_MAX    = (LAT_REQ > TIMEOUT) ? LAT_REQ : TIMEOUT;
  localparam int                 c_CNT_W      = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_DELAY_LAST = c_CNT_W'(LAT_REQ - 1);
  localparam logic [c_CNT_W-1:0] c_WAIT_LAST  = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt;

  logic                r_pend_i;
  logic [ADDR_W-1:0]   r_i_addr;
  logic                r_pend_d;
  logic [ADDR_W-1:0]   r_d_addr;
  logic                r_d_store;
  logic [LINE_W-1:0]   r_d_data;

  logic                r_gnt;        // 0 = I$, 1 = D$
  logic [ADDR_W-1:0]   r_req_addr;
  logic                r_req_store;
  logic [LINE_W-1:0]   r_req_data;

  logic                r_rsp_valid;
  logic                r_rsp_id;
  logic [LINE_W-1:0]   r_rsp_data;
  logic                r_rsp_err;
  logic                r_proto_err;

  logic                w_any_pend;
  logic                w_rsp_hit;
  logic                w_timeout;
  logic                w_done;
  logic                w_done_i;
  logic                w_done_d;
  logic                w_drop_i;
  logic                w_drop_d;

  // A transaction completes either on a memory response or on the watchdog;
  // a response arriving in the watchdog's last cycle still wins.
  assign w_any_pend = r_pend_i | r_pend_d;
  assign w_rsp_hit  = (r_state == S_WAIT) && mm_rsp_valid;
  assign w_timeout  = (r_state == S_WAIT) && !mm_rsp_valid && (r_cnt == c_WAIT_LAST);
  assign w_done     = w_rsp_hit | w_timeout;
  assign w_done_i   = w_done && !r_gnt;
  assign w_done_d   = w_done &&  r_gnt;
  assign w_drop_i   = icache_req_valid && r_pend_i && !w_done_i;
  assign w_drop_d   = dcache_req_valid && r_pend_d && !w_done_d;

  assign mm_req_valid  = (r_state == S_ISSUE);
  assign mm_req_addr   = r_req_addr;
  assign mm_req_store  = r_req_store;
  assign mm_req_data   = r_req_data;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_cache_id  = r_rsp_id;
  assign rsp_data      = r_rsp_data;
  assign rsp_bus_error = r_rsp_err;
  assign protocol_err  = r_proto_err;

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_pend)                  w_state_nxt = S_DELAY;
      S_DELAY: if (r_cnt == c_DELAY_LAST)       w_state_nxt = S_ISSUE;
      S_ISSUE: if (mm_req_ready)                w_state_nxt = S_WAIT;
      S_WAIT:  if (w_done)                      w_state_nxt = S_IDLE;
      default:                                  w_state_nxt = S_IDLE;
    endcase
  end

  // Phase counter: restarts at 0 on every state change
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                       r_cnt <= '0;
    else if (w_state_nxt != r_state)                    r_cnt <= '0;
    else if (r_state == S_DELAY || r_state == S_WAIT)   r_cnt <= r_cnt + c_CNT_W'(1);
  end

  // Grant and request fields latched when leaving IDLE; D$ has priority
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt       <= 1'b0;
      r_req_addr  <= '0;
      r_req_store <= 1'b0;
      r_req_data  <= '0;
    end else if (r_state == S_IDLE && w_any_pend) begin
      r_gnt       <= r_pend_d;
      r_req_addr  <= r_pend_d ? r_d_addr : r_i_addr;
      r_req_store <= r_pend_d & r_d_store;
      r_req_data  <= r_pend_d ? r_d_data : '0;
    end
  end

  // I$ pending buffer; a refill may be re-armed in its own completion cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_i <= 1'b0;
      r_i_addr <= '0;
    end else if (icache_req_valid && (!r_pend_i || w_done_i)) begin
      r_pend_i <= 1'b1;
      r_i_addr <= icache_req_addr;
    end else if (w_done_i) begin
      r_pend_i <= 1'b0;
    end
  end

  // D$ pending buffer; same capture rule as the I$ side
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_d  <= 1'b0;
      r_d_addr  <= '0;
      r_d_store <= 1'b0;
      r_d_data  <= '0;
    end else if (dcache_req_valid && (!r_pend_d || w_done_d)) begin
      r_pend_d  <= 1'b1;
      r_d_addr  <= dcache_req_addr;
      r_d_store <= dcache_req_store;
      r_d_data  <= dcache_req_data;
    end else if (w_done_d) begin
      r_pend_d  <= 1'b0;
    end
  end

  // Sticky flag for a request dropped because its cache was already pending
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                  r_proto_err <= 1'b0;
    else if (w_drop_i || w_drop_d) r_proto_err <= 1'b1;
  end

  // Response pulse; payload fields hold between pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_done;
      if (w_done) begin
        r_rsp_id   <= r_gnt;
        r_rsp_data <= (w_rsp_hit && !r_req_store && !mm_rsp_error) ? mm_rsp_data : '0;
        r_rsp_err  <= w_timeout | (w_rsp_hit & mm_rsp_error);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_miss_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_miss_arbiter
//  Description : Self-checking bench for mem_miss_arbiter. A behavioural
//                memory model answers requests, a scoreboard holds the
//                expected response per cache, and a monitor checks each
//                response pulse against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_miss_arbiter;

  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 128;
  localparam int LAT_REQ = 4;
  localparam int TIMEOUT = 255;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              icache_req_valid = 1'b0;
  logic [ADDR_W-1:0] icache_req_addr = '0;
  logic              dcache_req_valid = 1'b0;
  logic [ADDR_W-1:0] dcache_req_addr = '0;
  logic              dcache_req_store = 1'b0;
  logic [LINE_W-1:0] dcache_req_data = '0;
  logic              mm_req_valid;
  logic              mm_req_ready;
  logic [ADDR_W-1:0] mm_req_addr;
  logic              mm_req_store;
  logic [LINE_W-1:0] mm_req_data;
  logic              mm_rsp_valid;
  logic [LINE_W-1:0] mm_rsp_data;
  logic              mm_rsp_error;
  logic              rsp_valid;
  logic              rsp_cache_id;
  logic [LINE_W-1:0] rsp_data;
  logic              rsp_bus_error;
  logic              protocol_err;

  mem_miss_arbiter #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .LAT_REQ(LAT_REQ), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
    .dcache_req_valid(dcache_req_valid), .dcache_req_addr(dcache_req_addr),
    .dcache_req_store(dcache_req_store), .dcache_req_data(dcache_req_data),
    .mm_req_valid(mm_req_valid), .mm_req_ready(mm_req_ready),
    .mm_req_addr(mm_req_addr), .mm_req_store(mm_req_store), .mm_req_data(mm_req_data),
    .mm_rsp_valid(mm_rsp_valid), .mm_rsp_data(mm_rsp_data), .mm_rsp_error(mm_rsp_error),
    .rsp_valid(rsp_valid), .rsp_cache_id(rsp_cache_id), .rsp_data(rsp_data),
    .rsp_bus_error(rsp_bus_error), .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              store;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] edata;
    logic              eerr;
  } txn_t;

  txn_t q_i[$];
  txn_t q_d[$];
  logic rsp_ids[$];
  int   total = 0;
  int   bad   = 0;
  int   n_rsp = 0;
  int   rsp_cyc = 0;

  // memory model configuration and state
  int                stall_cfg = 0;   // -1 = random
  int                dly_cfg   = 0;   // -1 = random
  bit                silent    = 1'b0;
  int                stall_left = 0;
  int                rsp_cnt    = -1;
  bit                hold        = 1'b0;
  bit                outstanding = 1'b0;
  logic [ADDR_W-1:0] acc_addr = '0;
  logic              acc_store = 1'b0;
  logic [LINE_W-1:0] acc_data = '0;
  int                acc_cyc = 0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic              prev_store = 1'b0;
  logic [LINE_W-1:0] prev_data = '0;

  function automatic logic [LINE_W-1:0] mem_line(input logic [ADDR_W-1:0] a);
    return {a ^ 32'hDEAD_BEEF, ~a, a * 32'd3, a + 32'd1};
  endfunction

  function automatic logic mem_err(input logic [ADDR_W-1:0] a);
    return a[4];
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Memory: drives ready/response on the falling edge
  initial begin
    mm_req_ready = 1'b0;
    mm_rsp_valid = 1'b0;
    mm_rsp_data  = '0;
    mm_rsp_error = 1'b0;
    forever begin
      @(negedge clock);
      mm_rsp_valid = 1'b0;
      mm_rsp_error = 1'b0;
      mm_req_ready = 1'b0;
      if (!reset_n) begin
        hold = 1'b0; rsp_cnt = -1; outstanding = 1'b0;
      end else begin
        if (rsp_cnt == 0) begin
          mm_rsp_valid = 1'b1;
          mm_rsp_data  = mem_line(acc_addr);
          mm_rsp_error = mem_err(acc_addr);
          rsp_cnt = -1;
        end else if (rsp_cnt > 0) begin
          rsp_cnt--;
        end
        if (mm_req_valid) begin
          if (hold) begin
            chk("req_addr_stable",  256'(mm_req_addr),  256'(prev_addr));
            chk("req_store_stable", 256'(mm_req_store), 256'(prev_store));
            chk("req_data_stable",  256'(mm_req_data),  256'(prev_data));
          end else begin
            chk("no_req_overlap", 256'(outstanding), 256'(0));
            stall_left = (stall_cfg >= 0) ? stall_cfg : int'($urandom_range(0, 3));
          end
          prev_addr = mm_req_addr; prev_store = mm_req_store; prev_data = mm_req_data;
          if (stall_left == 0) begin
            mm_req_ready = 1'b1;
            acc_addr = mm_req_addr; acc_store = mm_req_store; acc_data = mm_req_data;
            acc_cyc = cyc;
            outstanding = 1'b1;
            hold = 1'b0;
            rsp_cnt = silent ? TIMEOUT + 5 :
                      ((dly_cfg >= 0) ? dly_cfg : int'($urandom_range(0, 4)));
          end else begin
            stall_left--;
            hold = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each response pulse
  initial begin
    txn_t t;
    forever begin
      @(negedge clock);
      if (reset_n && rsp_valid) begin
        n_rsp++;
        rsp_cyc = cyc;
        rsp_ids.push_back(rsp_cache_id);
        outstanding = 1'b0;
        if ((rsp_cache_id && q_d.size() == 0) || (!rsp_cache_id && q_i.size() == 0)) begin
          total++; bad++;
          $display("FAIL unexpected_rsp: got response id=%0d want no response", rsp_cache_id);
        end else begin
          t = rsp_cache_id ? q_d.pop_front() : q_i.pop_front();
          chk("rsp_data",       256'(rsp_data),      256'(t.edata));
          chk("rsp_bus_error",  256'(rsp_bus_error), 256'(t.eerr));
          chk("route_addr",     256'(acc_addr),      256'(t.addr));
          chk("route_store",    256'(acc_store),     256'(t.store));
          if (t.store) chk("req_wdata", 256'(acc_data), 256'(t.wdata));
        end
      end
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
    icache_req_valid = 1'b0;
    dcache_req_valid = 1'b0;
  endtask

  task automatic req_i(input logic [ADDR_W-1:0] a);
    txn_t t;
    icache_req_valid = 1'b1;
    icache_req_addr  = a;
    t.addr = a; t.store = 1'b0; t.wdata = '0;
    t.eerr  = silent | mem_err(a);
    t.edata = t.eerr ? '0 : mem_line(a);
    q_i.push_back(t);
  endtask

  task automatic req_d(input logic [ADDR_W-1:0] a, input logic st, input logic [LINE_W-1:0] wd);
    txn_t t;
    dcache_req_valid = 1'b1;
    dcache_req_addr  = a;
    dcache_req_store = st;
    dcache_req_data  = wd;
    t.addr = a; t.store = st; t.wdata = wd;
    t.eerr  = silent | mem_err(a);
    t.edata = (t.eerr || st) ? '0 : mem_line(a);
    q_d.push_back(t);
  endtask

  task automatic wait_rsps(input int target, input int budget);
    int k = 0;
    while (n_rsp < target && k < budget) begin
      step();
      k++;
    end
    if (n_rsp < target) begin
      total++; bad++;
      $display("FAIL wait_rsp: got %0d responses want %0d", n_rsp, target);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int                c;
    int                n0;
    logic [ADDR_W-1:0] a;
    logic [LINE_W-1:0] wd;

    // reset state
    idle(3);
    chk("reset_mm_req_valid", 256'(mm_req_valid), 256'(0));
    chk("reset_rsp", 256'({rsp_valid, rsp_cache_id, rsp_bus_error, protocol_err}), 256'(0));
    chk("reset_rsp_data", 256'(rsp_data), 256'(0));
    chk("reset_mm_req", 256'({mm_req_addr, mm_req_store}), 256'(0));
    reset_n = 1'b1;
    idle(2);

    // single I$ fill, zero-wait memory: fixed latency
    c = cyc;
    req_i(32'h0000_1000);
    wait_rsps(n_rsp + 1, 40);
    chk("fill_latency", 256'(rsp_cyc - c), 256'(1 + 1 + LAT_REQ + 1 + 1));
    chk("fill_id", 256'(rsp_ids[rsp_ids.size()-1]), 256'(0));
    idle(3);

    // simultaneous pulses: D$ served before I$
    rsp_ids.delete();
    req_i(32'h0000_1100);
    req_d(32'h0000_2200, 1'b0, '0);
    step();
    wait_rsps(n_rsp + 2, 60);
    chk("prio_first_id",  256'(rsp_ids[0]), 256'(1));
    chk("prio_second_id", 256'(rsp_ids[1]), 256'(0));
    idle(3);

    // D$ arrives while I$ is waiting for memory; D$ request stalled 5 cycles
    rsp_ids.delete();
    dly_cfg = 3;
    req_i(32'h0000_1200);
    step();
    for (int k = 0; k < 40 && !outstanding; k++) step();
    chk("i_in_wait", 256'(outstanding), 256'(1));
    stall_cfg = 5;
    req_d(32'h0000_2300, 1'b0, '0);
    step();
    wait_rsps(n_rsp + 2, 80);
    chk("wait_first_id",  256'(rsp_ids[0]), 256'(0));
    chk("wait_second_id", 256'(rsp_ids[1]), 256'(1));
    stall_cfg = 0; dly_cfg = 0;
    idle(3);

    // D$ writeback store
    wd = {4{32'hA5A5_A5A5}};
    req_d(32'h0000_2000, 1'b1, wd);
    wait_rsps(n_rsp + 1, 40);
    chk("store_flag", 256'(acc_store), 256'(1));
    chk("store_data", 256'(acc_data), 256'(wd));
    idle(3);

    // new I$ pulse in the same cycle its previous response is produced
    c = cyc;
    req_i(32'h0000_1300);
    idle(7);
    req_i(32'h0000_1340);
    wait_rsps(n_rsp + 2, 60);
    chk("recapture_no_proto_err", 256'(protocol_err), 256'(0));
    idle(3);

    // memory never answers: watchdog response, then normal service
    silent = 1'b1;
    req_i(32'h0000_3000);
    wait_rsps(n_rsp + 1, TIMEOUT + 60);
    chk("timeout_latency", 256'(rsp_cyc - acc_cyc), 256'(TIMEOUT + 1));
    silent = 1'b0;
    idle(20);
    req_d(32'h0000_3100, 1'b0, '0);
    wait_rsps(n_rsp + 1, 40);
    idle(3);

    // randomized traffic
    stall_cfg = -1; dly_cfg = -1;
    for (int k = 0; k < 2000; k++) begin
      step();
      if (q_i.size() == 0 && $urandom_range(0, 7) == 0) begin
        a = $urandom;
        req_i(a);
      end
      if (q_d.size() == 0 && $urandom_range(0, 7) == 0) begin
        a  = $urandom;
        wd = {$urandom, $urandom, $urandom, $urandom};
        req_d(a, 1'($urandom_range(0, 1)), wd);
      end
    end
    for (int k = 0; k < 400 && (q_i.size() + q_d.size()) != 0; k++) step();
    chk("random_drained", 256'(q_i.size() + q_d.size()), 256'(0));
    chk("random_no_proto_err", 256'(protocol_err), 256'(0));
    stall_cfg = 0; dly_cfg = 0;
    idle(3);

    // second D$ pulse while D$ pending: dropped, sticky error
    req_d(32'h0000_4000, 1'b0, '0);
    step();
    dcache_req_valid = 1'b1;
    dcache_req_addr  = 32'h0000_4040;
    dcache_req_store = 1'b0;
    step();
    chk("proto_err_set", 256'(protocol_err), 256'(1));
    wait_rsps(n_rsp + 1, 40);
    idle(5);
    chk("proto_err_sticky", 256'(protocol_err), 256'(1));

    // reset asserted while in DELAY aborts the transaction
    req_d(32'h0000_5000, 1'b0, '0);
    idle(3);
    reset_n = 1'b0;
    #1;
    chk("midreset_mm", 256'({mm_req_valid, mm_req_store, mm_req_addr}), 256'(0));
    chk("midreset_rsp", 256'({rsp_valid, rsp_cache_id, rsp_bus_error, protocol_err}), 256'(0));
    chk("midreset_data", 256'(rsp_data), 256'(0));
    q_i.delete(); q_d.delete();
    idle(2);
    reset_n = 1'b1;
    n0 = n_rsp;
    idle(30);
    chk("no_rsp_after_reset", 256'(n_rsp), 256'(n0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
